imm_decode_stage: RTL

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_pkg.sv | 25 ++
 rtl/imm_decode_comb.sv | 67 ++++++
 rtl/imm_decode_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imm_decode_pkg.sv
// Shared decode package for the immediate decode stage.
//   imm_sel_e  : immediate format selector carried on in_sel
//   XLEN_A/B   : the two datapath widths the decoder supports
//   xlen_legal : elaboration-time check that a chosen XLEN is one of them
package imm_decode_pkg;

   typedef enum logic [2:0] {
      IMM_I     = 3'd0,
      IMM_S     = 3'd1,
      IMM_B     = 3'd2,
      IMM_J     = 3'd3,
      IMM_U     = 3'd4,
      IMM_SHAMT = 3'd5,
      IMM_CSR   = 3'd6,
      IMM_NONE  = 3'd7
   } imm_sel_e;

   localparam int unsigned XLEN_A = 32;
   localparam int unsigned XLEN_B = 64;

   function automatic bit xlen_legal(input int unsigned xlen);
      return (xlen == XLEN_A) || (xlen == XLEN_B);
   endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational immediate decoder.
//   inst    : raw 32-bit instruction word
//   sel     : immediate format (imm_sel_e encoding)
//   imm     : decoded immediate, sign- or zero-extended to XLEN
//   illegal : encoding is not valid for this XLEN
module imm_decode_comb
   import imm_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [2:0]      sel,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   imm_sel_e sel_e;
   assign sel_e = imm_sel_e'(sel);

   // Raw immediate fields as signed values so the XLEN cast sign-extends from inst[31].
   logic signed [11:0] i_fld;
   logic signed [11:0] s_fld;
   logic signed [12:0] b_fld;
   logic signed [20:0] j_fld;
   logic signed [31:0] u_fld;

   assign i_fld = inst[31:20];
   assign s_fld = {inst[31:25], inst[11:7]};
   assign b_fld = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign j_fld = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign u_fld = {inst[31:12], 12'h000};

   // The opcode field never contributes to any immediate.
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   logic signed [XLEN-1:0] imm_s;

   always_comb begin
      imm_s   = '0;
      illegal = 1'b0;
      case (sel_e)
         IMM_I: imm_s = XLEN'(i_fld);
         IMM_S: imm_s = XLEN'(s_fld);
         IMM_B: imm_s = XLEN'(b_fld);
         IMM_J: imm_s = XLEN'(j_fld);
         IMM_U: imm_s = XLEN'(u_fld);
         IMM_SHAMT: begin
            // RV32 shifts only have 5 shamt bits; inst[25] set is a reserved encoding.
            if (XLEN == 32) begin
               imm_s   = XLEN'(inst[24:20]);
               illegal = inst[25];
            end else begin
               imm_s   = XLEN'(inst[25:20]);
            end
         end
         IMM_CSR: imm_s = XLEN'(inst[19:15]);
         default: begin
            imm_s   = '0;
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = imm_s;

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage with a 2-entry skid buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous kill of both held entries
//   in_valid/in_ready   : upstream handshake (in_ready is registered)
//   in_inst/in_sel      : instruction word and immediate format
//   in_tag              : sideband tag travelling with the instruction
//   out_valid/out_ready : downstream handshake
//   out_imm/out_tag     : decoded immediate and its tag
//   out_illegal         : encoding illegal for XLEN
module imm_decode_stage
   import imm_decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   if (!xlen_legal(XLEN)) begin : g_xlen_check
      $error("imm_decode_stage: XLEN must be 32 or 64");
   end

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0] state;

   // ---- stage p0: combinational decode of the incoming instruction ----
   logic [XLEN-1:0] imm_p0;
   logic            illegal_p0;

   imm_decode_comb #(.XLEN(XLEN)) u_dec (
      .inst    (in_inst),
      .sel     (in_sel),
      .imm     (imm_p0),
      .illegal (illegal_p0)
   );

   logic accept;
   logic drain;
   logic load_out;
   logic load_skid;
   logic from_skid;

   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid && in_ready && !flush;
   assign drain     = out_valid && out_ready;

   // Output register takes the new decode when empty, or when it is being
   // replaced in the same cycle it drains (full throughput path).
   assign load_out  = accept && ((state == ST_EMPTY) || (state == ST_ONE && drain));
   assign load_skid = accept && (state == ST_ONE) && !drain;
   assign from_skid = !flush && (state == ST_TWO) && drain;

   // ---- stage p1: skid register and output register ----
   logic [XLEN-1:0]  skid_imm_p1;
   logic [TAG_W-1:0] skid_tag_p1;
   logic             skid_illegal_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b1;
      end else if (flush) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) state <= ST_ONE;
            end
            ST_ONE: begin
               if (accept && !drain) begin
                  state    <= ST_TWO;
                  in_ready <= 1'b0;
               end else if (!accept && drain) begin
                  state    <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  state    <= ST_ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= ST_EMPTY;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_imm     <= '0;
         out_tag     <= '0;
         out_illegal <= 1'b0;
      end else if (load_out) begin
         out_imm     <= imm_p0;
         out_tag     <= in_tag;
         out_illegal <= illegal_p0;
      end else if (from_skid) begin
         out_imm     <= skid_imm_p1;
         out_tag     <= skid_tag_p1;
         out_illegal <= skid_illegal_p1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_imm_p1     <= '0;
         skid_tag_p1     <= '0;
         skid_illegal_p1 <= 1'b0;
      end else if (load_skid) begin
         skid_imm_p1     <= imm_p0;
         skid_tag_p1     <= in_tag;
         skid_illegal_p1 <= illegal_p0;
      end
   end

endmodule
